// File: rtl/fifo_input_buffer.sv
// Per-input-port flit FIFO in front of the LBDR routing stage: first-word-fall-through head
// with decoded flit_id/dst_addr, one credit returned upstream per flit read out.
module fifo_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count,
  output logic                  credit_out,
  output logic                  overflow
);

  localparam logic [2:0]     HEADER     = 3'b001;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [3:0]            hdr_dst;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A read frees a slot on the same edge, so a full FIFO still accepts a write alongside a pop.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign data_out = empty ? '0 : mem[rd_ptr];
  assign flit_id  = data_out[DATA_WIDTH-1 -: 3];
  assign dst_addr = (flit_id == HEADER) ? data_out[3:0] : hdr_dst;

  // NOTE: the flit storage has no reset; empty masks stale entries, and leaving it unreset
  // lets it map onto plain RAM/register-file cells without a reset network.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      credit_out <= 1'b0;
      overflow   <= 1'b0;
      hdr_dst    <= '0;
    end else begin
      credit_out <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full && !rd_acc) overflow <= 1'b1;
      // Payload and tail flits inherit the destination of the header popped ahead of them.
      if (rd_acc && flit_id == HEADER) hdr_dst <= data_out[3:0];
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_input_buffer.sv
// Scoreboard bench for fifo_input_buffer: the driver keeps a queue-level model of the FIFO and
// pushes expected flits; an independent negedge monitor compares every presented head flit.
module tb_fifo_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          empty;
  logic          full;
  logic [PTR_W:0] count;
  logic          credit_out;
  logic          overflow;

  fifo_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr), .empty(empty),
    .full(full), .count(count), .credit_out(credit_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] flit;
    logic [3:0]    dst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: occupancy, sticky overflow, expected credit, last accepted header dst.
  int         m_count;
  logic       m_ovf;
  logic       m_credit;
  logic [3:0] wr_hdr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
    check({tag, "_credit"}, 32'(credit_out), 32'(m_credit));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Called at posedge+1; drives one cycle of stimulus, advances the model, checks after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit   rd_ok;
    bit   wr_ok;
    exp_t e;
    wr_en   = wr;
    data_in = d;
    rd_en   = rd;
    rd_ok = rd && (m_count > 0);
    wr_ok = wr && ((m_count < DEPTH) || rd_ok);
    if (wr_ok) begin
      if (d[31:29] == ID_HEADER) wr_hdr = d[3:0];
      e.flit = d;
      e.dst  = wr_hdr;
      sb.push_back(e);
    end
    if (wr && m_count == DEPTH && !rd_ok) m_ovf = 1'b1;
    m_count  = m_count + int'(wr_ok) - int'(rd_ok);
    m_credit = rd_ok;
    @(posedge clk);
    #1;
    check_status("cyc");
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_credit", 32'(credit_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    sb.delete();
    m_count  = 0;
    m_ovf    = 1'b0;
    m_credit = 1'b0;
    wr_hdr   = 4'h0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_flit();
    logic [DW-1:0] f;
    logic [2:0]    id;
    f = $urandom;
    case ($urandom_range(0, 5))
      0, 1:    id = ID_HEADER;
      2, 3:    id = ID_PAYLOAD;
      4:       id = ID_TAIL;
      default: id = 3'($urandom_range(0, 7));
    endcase
    f[31:29] = id;
    return f;
  endfunction

  // Monitor: compares the presented head against the scoreboard and retires it when popped.
  always @(negedge clk) begin
    if (!rst) begin
      if (empty) begin
        check("empty_data_out", data_out, 32'd0);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected: got 0x%0h expected no flit at %0t", data_out, $time);
      end else begin
        check("head_data", data_out, sb[0].flit);
        check("head_flit_id", 32'(flit_id), 32'(sb[0].flit[31:29]));
        check("head_dst_addr", 32'(dst_addr), 32'(sb[0].dst));
        if (rd_en) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    m_count = 0; m_ovf = 1'b0; m_credit = 1'b0; wr_hdr = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, '0, 1'b0);

    // Header into empty FIFO: visible one cycle later with decoded id and destination.
    step(1'b1, 32'h2000_000A, 1'b0);
    check("t2_flit_id", 32'(flit_id), 32'(ID_HEADER));
    check("t2_dst_addr", 32'(dst_addr), 32'hA);
    step(1'b0, '0, 1'b1);

    // Async reset mid-stream while credit_out is high.
    step(1'b1, 32'h4000_0001, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();

    // Packet H(dst=6),P,P,T: every head must carry destination 6.
    step(1'b1, 32'h2000_0006, 1'b0);
    step(1'b1, 32'h4000_000F, 1'b0);
    step(1'b1, 32'h4123_4563, 1'b0);
    step(1'b1, 32'h8000_0009, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t3_dst_addr", 32'(dst_addr), 32'h6);
      step(1'b0, '0, 1'b1);
    end

    // Overfill: fifth flit dropped, overflow sticky.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h4000_0000 | 32'(i + 1), 1'b0);
    check("t4_full", 32'(full), 32'd1);
    check("t4_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Full FIFO with simultaneous read and write.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0010 | 32'(i), 1'b0);
    step(1'b1, 32'h4000_00AA, 1'b1);
    check("t5_count", 32'(count), 32'd4);
    check("t5_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Streaming through two pointer wraps.
    do_reset();
    step(1'b1, 32'h2000_0003, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, 32'h4000_0100 | 32'(i), 1'b1);
    check("t6_count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(($urandom_range(0, 99) < 60), rand_flit(), ($urandom_range(0, 99) < 50));
    end
    while (m_count > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
